// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit memory stage.
//   lsu_state_e : FSM states of lsu_mem_stage (IDLE -> REQ -> RESP)
//   lsu_size_e  : access size decoded from the RV32 funct3 code
//   F3_*        : RV32 load/store funct3 encodings
//   f3_size()   : funct3 -> access size (reserved codes decode as word)
//   f3_bytes()  : number of bytes touched by an access size
// ----------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Size lives in funct3[1:0]; any code with bit 1 set (010, 011, 110, 111)
   // is handled as a full word, which folds the reserved codes into LW/SW.
   function automatic lsu_size_e f3_size(input logic [2:0] f3);
      lsu_size_e sz;
      case (f3[1:0])
         F3_B[1:0]: sz = SZ_B;
         F3_H[1:0]: sz = SZ_H;
         default:   sz = SZ_W;
      endcase
      return sz;
   endfunction

   function automatic logic [2:0] f3_bytes(input lsu_size_e sz);
      logic [2:0] n;
      case (sz)
         SZ_B:    n = 3'd1;
         SZ_H:    n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering for the LSU.
//   offset     in  : byte offset within the word (addr[1:0])
//   funct3     in  : RV32 width/sign code
//   store_data in  : LSB-aligned store data
//   load_word  in  : raw word returned by data memory
//   wmask      out : 4-bit byte-lane write mask
//   wdata      out : store data shifted onto its byte lanes
//   load_data  out : load data shifted down and sign/zero extended
// Lanes that would spill past byte 3 (misaligned half/word) are simply
// truncated by the shifts.
// ----------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] load_word,
   output logic [3:0]      wmask,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_data
);

   lsu_size_e       size;
   logic [2:0]      nbytes;
   logic [4:0]      bit_shift;
   logic [XLEN-1:0] lane_data;
   logic [XLEN-1:0] shifted;

   assign size      = f3_size(funct3);
   assign nbytes    = f3_bytes(size);
   assign bit_shift = {offset, 3'b000};

   // A lane is written when it falls inside [offset, offset+nbytes); lanes
   // beyond byte 3 do not exist, which gives the truncation for free.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_mask
         localparam logic [1:0] LANE = 2'(gi);
         assign wmask[gi] = (offset <= LANE) && ({1'b0, LANE - offset} < nbytes);
      end
   endgenerate

   always_comb begin
      lane_data = '0;
      case (size)
         SZ_B:    lane_data = {{(XLEN-8){1'b0}},  store_data[7:0]};
         SZ_H:    lane_data = {{(XLEN-16){1'b0}}, store_data[15:0]};
         default: lane_data = store_data;
      endcase
   end

   assign wdata   = lane_data << bit_shift;
   assign shifted = load_word >> bit_shift;

   // funct3[2] set means unsigned (LBU/LHU); it is ignored for words.
   always_comb begin
      load_data = shifted;
      case (size)
         SZ_B:    load_data = {{(XLEN-8){shifted[7] & ~funct3[2]}},   shifted[7:0]};
         SZ_H:    load_data = {{(XLEN-16){shifted[15] & ~funct3[2]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// ----------------------------------------------------------------------------
// lsu_mem_stage
// Load/store unit between execute and the unified data-memory port.
// One op is accepted per in_valid/in_ready handshake, issued to memory as a
// d_valid request held until d_ready, and the result is returned to
// write-back over out_valid/out_ready. Ops never overlap.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready               upstream handshake
//   in_addr, in_wdata               effective address, LSB-aligned store data
//   in_funct3, in_is_load/is_store  RV32 width code and op kind
//   out_valid/out_ready             write-back handshake
//   out_rdata                       extended load data (0 for store/non-mem)
//   out_err                         misaligned-access flag
//   d_valid, d_addr, d_wen,
//   d_wdata, d_wmask                memory request (word-aligned address)
//   d_rdata, d_ready                memory response / completion
//
// Configuration macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned half/word ops skip memory and return out_err=1
//   undefined : out_err stays 0 and misaligned ops issue with truncated lanes
// ----------------------------------------------------------------------------
module lsu_mem_stage
   import lsu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int MASK_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   input  logic [2:0]        in_funct3,
   input  logic              in_is_load,
   input  logic              in_is_store,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_rdata,
   output logic              out_err,
   output logic              d_valid,
   output logic [XLEN-1:0]   d_addr,
   output logic              d_wen,
   output logic [XLEN-1:0]   d_wdata,
   output logic [MASK_W-1:0] d_wmask,
   input  logic [XLEN-1:0]   d_rdata,
   input  logic              d_ready
);

   lsu_state_e      state_reg,    state_next;
   logic [XLEN-1:0] addr_reg,     addr_next;
   logic [XLEN-1:0] wdata_reg,    wdata_next;
   logic [2:0]      funct3_reg,   funct3_next;
   logic            is_load_reg,  is_load_next;
   logic            is_store_reg, is_store_next;
   logic [XLEN-1:0] rdata_reg,    rdata_next;
   logic            err_reg,      err_next;

   logic [3:0]      lane_mask;
   logic [XLEN-1:0] lane_wdata;
   logic [XLEN-1:0] load_data;
   logic            misalign;
   logic            in_req;
   logic            st_req;

   lsu_align #(.XLEN(XLEN)) u_align (
      .offset     (addr_reg[1:0]),
      .funct3     (funct3_reg),
      .store_data (wdata_reg),
      .load_word  (d_rdata),
      .wmask      (lane_mask),
      .wdata      (lane_wdata),
      .load_data  (load_data)
   );

   // Alignment is judged on the incoming op so a bad access never reaches
   // memory. With the check disabled this is constant 0 and err_reg folds
   // away to a tied-off output.
`ifdef LSU_MISALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      if (in_is_load || in_is_store) begin
         case (f3_size(in_funct3))
            SZ_H:    misalign = in_addr[0];
            SZ_W:    misalign = (in_addr[1:0] != 2'b00);
            default: misalign = 1'b0;
         endcase
      end
   end
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      funct3_next   = funct3_reg;
      is_load_next  = is_load_reg;
      is_store_next = is_store_reg;
      rdata_next    = rdata_reg;
      err_next      = err_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               addr_next     = in_addr;
               wdata_next    = in_wdata;
               funct3_next   = in_funct3;
               is_load_next  = in_is_load;
               is_store_next = in_is_store;
               rdata_next    = '0;
               err_next      = misalign;
               if ((in_is_load || in_is_store) && !misalign) begin
                  state_next = REQ;
               end else begin
                  state_next = RESP;
               end
            end
         end
         REQ: begin
            // Leaving REQ on the d_ready cycle guarantees a single accepted
            // request per op.
            if (d_ready) begin
               rdata_next = is_load_reg ? load_data : '0;
               state_next = RESP;
            end
         end
         RESP: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         funct3_reg   <= '0;
         is_load_reg  <= 1'b0;
         is_store_reg <= 1'b0;
         rdata_reg    <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         funct3_reg   <= funct3_next;
         is_load_reg  <= is_load_next;
         is_store_reg <= is_store_next;
         rdata_reg    <= rdata_next;
         err_reg      <= err_next;
      end
   end

   // Memory-side outputs are decoded from held registers, so they are stable
   // for the whole REQ residency and zero elsewhere (including after reset).
   assign in_req = (state_reg == REQ);
   assign st_req = in_req && is_store_reg;

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == RESP);
   assign out_rdata = rdata_reg;
   assign out_err   = err_reg;

   assign d_valid = in_req;
   assign d_addr  = in_req ? {addr_reg[XLEN-1:2], 2'b00} : '0;
   assign d_wen   = st_req;
   assign d_wdata = st_req ? lane_wdata : '0;
   assign d_wmask = st_req ? {{(MASK_W-4){1'b0}}, lane_mask} : '0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [2:0]  in_funct3;
   logic        in_is_load;
   logic        in_is_store;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rdata;
   logic        out_err;
   logic        d_valid;
   logic [31:0] d_addr;
   logic        d_wen;
   logic [31:0] d_wdata;
   logic [7:0]  d_wmask;
   logic [31:0] d_rdata;
   logic        d_ready;

   int total = 0;
   int bad   = 0;
   int hs_count = 0;

   always #5 clk = ~clk;

   lsu_mem_stage #(.XLEN(32), .MASK_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_addr     (in_addr),
      .in_wdata    (in_wdata),
      .in_funct3   (in_funct3),
      .in_is_load  (in_is_load),
      .in_is_store (in_is_store),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_rdata   (out_rdata),
      .out_err     (out_err),
      .d_valid     (d_valid),
      .d_addr      (d_addr),
      .d_wen       (d_wen),
      .d_wdata     (d_wdata),
      .d_wmask     (d_wmask),
      .d_rdata     (d_rdata),
      .d_ready     (d_ready)
   );

   // Counts accepted memory requests (d_valid & d_ready on a rising edge).
   always @(posedge clk) begin
      if (d_valid && d_ready) hs_count <= hs_count + 1;
   end

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  exp_mask;
      logic [31:0] exp_wdata;
      logic [31:0] exp_out;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h want=%08h", name, act, exp);
      end
   endtask

   // Called 1ns after a rising edge with the DUT idle; returns 1ns after the
   // accepting edge.
   task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
      in_valid    = 1'b1;
      in_is_load  = ld;
      in_is_store = st;
      in_funct3   = f3;
      in_addr     = addr;
      in_wdata    = wdata;
      check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   int          hs0;
   logic [31:0] held_addr, held_wdata;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_funct3 = '0;
      in_is_load = 1'b0; in_is_store = 1'b0; out_ready = 1'b1; d_rdata = '0; d_ready = 1'b1;

      //            ld    st    f3     addr          wdata         rdata         mask  exp_wdata     exp_out
      vecs[0]  = '{1'b0, 1'b1, F3_B,  32'h8000_0003, 32'h1234_56AB, 32'h0,        4'h8, 32'hAB00_0000, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, F3_B,  32'h8000_0002, 32'h0,         32'h0080_0000, 4'h0, 32'h0,        32'hFFFF_FF80};
      vecs[2]  = '{1'b1, 1'b0, F3_BU, 32'h8000_0002, 32'h0,         32'h0080_0000, 4'h0, 32'h0,        32'h0000_0080};
      vecs[3]  = '{1'b1, 1'b0, F3_H,  32'h8000_0002, 32'h0,         32'h8001_0000, 4'h0, 32'h0,        32'hFFFF_8001};
      vecs[4]  = '{1'b1, 1'b0, F3_HU, 32'h8000_0002, 32'h0,         32'h8001_0000, 4'h0, 32'h0,        32'h0000_8001};
      vecs[5]  = '{1'b1, 1'b0, F3_W,  32'h8000_0000, 32'h0,         32'hDEAD_BEEF, 4'h0, 32'h0,        32'hDEAD_BEEF};
      vecs[6]  = '{1'b0, 1'b1, F3_H,  32'h8000_0002, 32'hCAFE_1234, 32'h0,        4'hC, 32'h1234_0000, 32'h0};
      vecs[7]  = '{1'b0, 1'b1, F3_W,  32'h8000_0004, 32'h1122_3344, 32'h0,        4'hF, 32'h1122_3344, 32'h0};
      vecs[8]  = '{1'b0, 1'b1, F3_B,  32'h8000_0001, 32'hFFFF_FF5A, 32'h0,        4'h2, 32'h0000_5A00, 32'h0};
      vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0,        32'h89AB_CDEF, 4'h0, 32'h0,        32'h89AB_CDEF};
      vecs[10] = '{1'b1, 1'b0, F3_B,  32'h0000_0000, 32'h0,         32'hFFFF_FF7F, 4'h0, 32'h0,        32'h0000_007F};
      vecs[11] = '{1'b1, 1'b0, F3_H,  32'h0000_0000, 32'h0,         32'h1234_FFFE, 4'h0, 32'h0,        32'hFFFF_FFFE};

      // Reset state
      step(); step();
      check("rst_in_ready",  {31'b0, in_ready},  32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_rdata", out_rdata,          32'd0);
      check("rst_out_err",   {31'b0, out_err},   32'd0);
      check("rst_d_valid",   {31'b0, d_valid},   32'd0);
      check("rst_d_wen",     {31'b0, d_wen},     32'd0);
      check("rst_d_addr",    d_addr,             32'd0);
      check("rst_d_wdata",   d_wdata,            32'd0);
      check("rst_d_wmask",   {24'b0, d_wmask},   32'd0);
      rst_n = 1'b1;
      step();

      // Table-driven ops with a combinational memory (d_ready tied high)
      for (int i = 0; i < NVEC; i++) begin
         d_rdata = vecs[i].rdata;
         hs0 = hs_count;
         drive_op(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
         // T+1: request on the memory port
         check("req_d_valid",   {31'b0, d_valid},   32'd1);
         check("req_in_ready",  {31'b0, in_ready},  32'd0);
         check("req_d_addr",    d_addr,             vecs[i].addr & 32'hFFFF_FFFC);
         check("req_d_wen",     {31'b0, d_wen},     {31'b0, vecs[i].st});
         check("req_d_wmask",   {24'b0, d_wmask},   {28'b0, vecs[i].exp_mask});
         check("req_d_wdata",   d_wdata,            vecs[i].exp_wdata);
         step();
         // T+2: result to write-back
         check("resp_out_valid", {31'b0, out_valid}, 32'd1);
         check("resp_d_valid",   {31'b0, d_valid},   32'd0);
         check("resp_out_rdata", out_rdata,          vecs[i].exp_out);
         check("resp_out_err",   {31'b0, out_err},   32'd0);
         check("resp_hs_count",  hs_count - hs0,     32'd1);
         step();
         check("back_idle", {31'b0, in_ready}, 32'd1);
         $display("op %0d ld=%0d st=%0d f3=%03b addr=%08h -> d_wmask=%02h d_wdata=%08h out_rdata=%08h",
                  i, vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, d_wmask, d_wdata, out_rdata);
      end

      // Non-memory op: straight to RESP with zero data, no request
      hs0 = hs_count;
      drive_op(1'b0, 1'b0, F3_W, 32'h1234_5678, 32'hFFFF_FFFF);
      check("nonmem_out_valid", {31'b0, out_valid}, 32'd1);
      check("nonmem_d_valid",   {31'b0, d_valid},   32'd0);
      check("nonmem_out_rdata", out_rdata,          32'd0);
      step();
      check("nonmem_hs_count", hs_count - hs0, 32'd0);
      $display("nonmem op -> out_rdata=%08h", out_rdata);

      // Write-back back-pressure: out_ready low for 5 cycles in RESP
      out_ready = 1'b0;
      d_rdata = 32'hA5A5_0F0F;
      drive_op(1'b1, 1'b0, F3_W, 32'h0000_0020, 32'h0);
      step();
      d_rdata = 32'h0;
      for (int c = 0; c < 5; c++) begin
         check("bp_out_valid", {31'b0, out_valid}, 32'd1);
         check("bp_out_rdata", out_rdata,          32'hA5A5_0F0F);
         check("bp_in_ready",  {31'b0, in_ready},  32'd0);
         check("bp_d_valid",   {31'b0, d_valid},   32'd0);
         step();
      end
      out_ready = 1'b1;
      check("bp_last_out_valid", {31'b0, out_valid}, 32'd1);
      step();
      check("bp_released_in_ready",  {31'b0, in_ready},  32'd1);
      check("bp_released_out_valid", {31'b0, out_valid}, 32'd0);
      $display("backpressure op -> held 5 cycles, released");

      // Memory stall: d_ready low for 3 cycles of REQ
      d_ready = 1'b0;
      hs0 = hs_count;
      drive_op(1'b0, 1'b1, F3_W, 32'h0000_0040, 32'h55AA_55AA);
      held_addr  = d_addr;
      held_wdata = d_wdata;
      check("stall_first_addr", held_addr, 32'h0000_0040);
      for (int c = 0; c < 3; c++) begin
         check("stall_d_valid", {31'b0, d_valid}, 32'd1);
         check("stall_d_addr",  d_addr,           held_addr);
         check("stall_d_wdata", d_wdata,          32'h55AA_55AA);
         step();
      end
      d_ready = 1'b1;
      check("stall_final_d_valid", {31'b0, d_valid}, 32'd1);
      step();
      check("stall_drop_d_valid", {31'b0, d_valid},   32'd0);
      check("stall_out_valid",    {31'b0, out_valid}, 32'd1);
      check("stall_hs_count",     hs_count - hs0,     32'd1);
      step();
      $display("stalled store -> one handshake, held_wdata=%08h", held_wdata);

      // Reset during REQ discards the op
      d_ready = 1'b0;
      hs0 = hs_count;
      drive_op(1'b1, 1'b0, F3_W, 32'h0000_0080, 32'h0);
      check("rstreq_d_valid_before", {31'b0, d_valid}, 32'd1);
      rst_n = 1'b0;
      step();
      check("rstreq_d_valid",   {31'b0, d_valid},   32'd0);
      check("rstreq_in_ready",  {31'b0, in_ready},  32'd1);
      check("rstreq_out_valid", {31'b0, out_valid}, 32'd0);
      check("rstreq_hs_count",  hs_count - hs0,     32'd0);
      rst_n = 1'b1;
      d_ready = 1'b1;
      step();
      check("rstreq_idle_after", {31'b0, in_ready}, 32'd1);
      $display("reset during REQ -> idle, d_valid=%0d", d_valid);

      // Misaligned word store
      hs0 = hs_count;
      drive_op(1'b0, 1'b1, F3_W, 32'h8000_0002, 32'hAABB_CCDD);
`ifdef LSU_MISALIGN_CHECK_EN
      check("mis_d_valid",   {31'b0, d_valid},   32'd0);
      check("mis_out_valid", {31'b0, out_valid}, 32'd1);
      check("mis_out_err",   {31'b0, out_err},   32'd1);
      check("mis_out_rdata", out_rdata,          32'd0);
      step();
      check("mis_hs_count",  hs_count - hs0,     32'd0);
`else
      check("mis_d_valid",   {31'b0, d_valid},   32'd1);
      check("mis_d_wmask",   {24'b0, d_wmask},   32'h0000_000C);
      check("mis_d_wdata",   d_wdata,            32'hCCDD_0000);
      step();
      check("mis_out_valid", {31'b0, out_valid}, 32'd1);
      check("mis_out_err",   {31'b0, out_err},   32'd0);
      check("mis_hs_count",  hs_count - hs0,     32'd1);
      step();
`endif
      $display("misaligned SW addr=80000002 -> out_err=%0d", out_err);
      check("mis_idle_after", {31'b0, in_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
